// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//
// Owns the shared 4-digit seven-segment display. It gives the display to one of
// two requesters using round-robin arbitration. An owner keeps the display for a
// minimum number of scan ticks so that the display does not flicker between
// sources. The block also generates the digit-scan timing. It drives the
// active-low anodes and the nibble for the current digit, and the existing
// nibble-to-segment decoders take that nibble as their input.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset; clears all state
//   req0/val0  requester 0 level request and 16-bit value ([3:0] = rightmost)
//   req1/val1  requester 1 level request and 16-bit value
//   gnt        one-hot grant (bit n = requester n owns), 2'b00 when idle
//   disp_val   registered copy of the owner's value
//   digit_sel  current scan digit index 0..3
//   an         active-low anodes, 4'b1111 when blank
//   digit_nib  disp_val nibble selected by digit_sel
//   blank      high when nobody owns the display
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
  parameter int SCAN_DIV   = 100000,  // clk cycles per digit slot, >= 2
  parameter int HOLD_TICKS = 1024     // minimum scan ticks per owner, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] val0,
  input  logic        req1,
  input  logic [15:0] val1,
  output logic [1:0]  gnt,
  output logic [15:0] disp_val,
  output logic [1:0]  digit_sel,
  output logic [3:0]  an,
  output logic [3:0]  digit_nib,
  output logic        blank
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [1:0]     digit_sel_q, digit_sel_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           last_owner_q, last_owner_d;
  logic [15:0]    disp_val_q, disp_val_d;

  logic tick;
  logic hold_expired;

  assign tick         = (div_q == DIV_MAX);
  assign hold_expired = tick && (hold_cnt_q >= HOLD_MAX);

  // The scan runs all the time. An ownership change does not restart it.
  assign div_d       = tick ? '0 : div_q + 1'b1;
  assign digit_sel_d = tick ? digit_sel_q + 2'd1 : digit_sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      digit_sel_q  <= 2'd0;
      hold_cnt_q   <= '0;
      last_owner_q <= 1'b1;  // so that req0 wins the first tie
      disp_val_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      digit_sel_q  <= digit_sel_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      disp_val_q   <= disp_val_d;
    end
  end

  // Next-state logic. A voluntary release is checked before hold expiry.
  // When the owner drops its request on the same edge that the hold expires,
  // the result is therefore a release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_owner_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                     state_d = req1 ? OWN1 : IDLE;
        else if (req1 && hold_expired) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                     state_d = req0 ? OWN0 : IDLE;
        else if (req0 && hold_expired) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entering an OWN state restarts the hold count and records the owner.
  // This also covers a direct OWN0 <-> OWN1 switch.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    disp_val_d   = disp_val_q;

    if (state_d != state_q && state_d == OWN0) begin
      hold_cnt_d   = '0;
      last_owner_d = 1'b0;
    end else if (state_d != state_q && state_d == OWN1) begin
      hold_cnt_d   = '0;
      last_owner_d = 1'b1;
    end else if (state_q != IDLE && tick && hold_cnt_q < HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    // The owner's value is copied on every edge, so disp_val follows it with
    // one cycle of latency. In IDLE, disp_val keeps its last value.
    if (state_q == OWN0)      disp_val_d = val0;
    else if (state_q == OWN1) disp_val_d = val1;
  end

  assign gnt       = {state_q == OWN1, state_q == OWN0};
  assign blank     = (state_q == IDLE);
  assign an        = blank ? 4'b1111 : ~(4'b0001 << digit_sel_q);
  assign digit_nib = disp_val_q[{digit_sel_q, 2'b00} +: 4];
  assign digit_sel = digit_sel_q;
  assign disp_val  = disp_val_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for seg_display_arbiter with SCAN_DIV=4 and HOLD_TICKS=3.
// Expected values go into a scoreboard queue when stimulus is driven. They are
// popped and compared when the DUT output is sampled, 1 time unit after the
// active clock edge.
// edge_cnt counts the clock edges since the last reset release. After k edges
// the divider equals k%4, and tick edges are k = 4, 8, 12, ...
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] val0, val1;
  logic [1:0]  gnt;
  logic [15:0] disp_val;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic [3:0]  digit_nib;
  logic        blank;

  int checks = 0;
  int errors = 0;
  int edge_cnt;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  seg_display_arbiter #(.SCAN_DIV(4), .HOLD_TICKS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .val0      (val0),
    .req1      (req1),
    .val1      (val1),
    .gnt       (gnt),
    .disp_val  (disp_val),
    .digit_sel (digit_sel),
    .an        (an),
    .digit_nib (digit_nib),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // gnt must never have both bits set.
  always @(negedge clk) begin
    checks++;
    assert (gnt !== 2'b11) else begin
      errors++;
      $error("FAIL gnt_onehot observed %b expected not 11", gnt);
    end
  end

  task automatic push(input string tag, input logic [15:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    sb_entry_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected queued entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.exp);
      end
      $display("check %-14s k=%0d observed %h expected %h", e.tag, edge_cnt, obs, e.exp);
    end
  endtask

  // Advance to the edge count target, then settle 1 time unit.
  task automatic goto_edge(input int target);
    checks++;
    assert (edge_cnt <= target) else begin
      errors++;
      $error("FAIL goto_edge observed %0d expected <= %0d", edge_cnt, target);
    end
    for (int n = 0; n < 1000 && edge_cnt < target; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] an_tab  [4];
  logic [3:0] nib_tab [4];

  initial begin
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    nib_tab = '{4'h4, 4'h3, 4'h2, 4'h1};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; val0 = 16'h0; val1 = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    goto_edge(5);

    // 1. Reset asserted in the middle of a cycle, with both requests idle.
    #2 reset = 1'b1;
    push("rst_gnt", 16'h0); push("rst_an", 16'hF); push("rst_blank", 16'h1);
    push("rst_nib", 16'h0); push("rst_dsel", 16'h0);
    #1;
    pop_check({14'h0, gnt}); pop_check({12'h0, an}); pop_check({15'h0, blank});
    pop_check({12'h0, digit_nib}); pop_check({14'h0, digit_sel});
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push("idle_dsel", 16'(i % 4));
      goto_edge(4 * i);
      pop_check({14'h0, digit_sel});
    end
    push("idle_gnt", 16'h0); pop_check({14'h0, gnt});

    // 2. Single owner scans its value across all four digits.
    req0 = 1'b1; val0 = 16'h1234;
    push("own0_gnt", 16'h1);
    goto_edge(17); pop_check({14'h0, gnt});
    push("own0_disp", 16'h1234);
    goto_edge(18); pop_check(disp_val);
    for (int d = 0; d < 4; d++) begin
      push("scan_an", {12'h0, an_tab[d]});
      push("scan_nib", {12'h0, nib_tab[d]});
      goto_edge(18 + 4 * d);
      pop_check({12'h0, an});
      pop_check({12'h0, digit_nib});
    end

    // 3. Round-robin hold. Requester 0 gets a fresh grant on edge 32, and
    // requester 1 rises one cycle later. The ticks on edges 36 and 40 count
    // the hold, and the tick on edge 44 switches the owner.
    req0 = 1'b0;
    goto_edge(31);
    req0 = 1'b1;
    push("rr_gnt_a", 16'h1);
    goto_edge(32);
    req1 = 1'b1; val1 = 16'hABCD;
    goto_edge(33); pop_check({14'h0, gnt});
    push("rr_gnt_hold", 16'h1);
    goto_edge(43); pop_check({14'h0, gnt});
    push("rr_gnt_sw", 16'h2);
    goto_edge(44); pop_check({14'h0, gnt});
    push("rr_disp1", 16'hABCD);
    goto_edge(45); pop_check(disp_val);
    val1 = 16'h5678;
    push("rr_disp_trk", 16'h5678);
    goto_edge(46); pop_check(disp_val);

    // 4. Voluntary release. The hold count is still 0, so the release is
    // not delayed.
    req1 = 1'b0;
    push("rel_gnt", 16'h1);
    goto_edge(47); pop_check({14'h0, gnt});
    push("rel_disp0", 16'h1234);
    goto_edge(48); pop_check(disp_val);
    req0 = 1'b0;
    push("rel_gnt_idle", 16'h0); push("rel_blank", 16'h1); push("rel_an", 16'hF);
    goto_edge(49);
    pop_check({14'h0, gnt}); pop_check({15'h0, blank}); pop_check({12'h0, an});
    val0 = 16'hFFFF;
    push("rel_disp_hold", 16'h1234);
    goto_edge(52); pop_check(disp_val);

    // 5. A tie right out of reset goes to requester 0, and the owner then
    // alternates at each hold expiry.
    #2 reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    push("tie_gnt0", 16'h1);
    goto_edge(1); pop_check({14'h0, gnt});
    push("tie_hold0", 16'h1);
    goto_edge(11); pop_check({14'h0, gnt});
    push("tie_gnt1", 16'h2);
    goto_edge(12); pop_check({14'h0, gnt});
    push("tie_disp1", 16'h5678);
    goto_edge(13); pop_check(disp_val);
    push("tie_hold1", 16'h2);
    goto_edge(23); pop_check({14'h0, gnt});
    push("tie_gnt0b", 16'h1);
    goto_edge(24); pop_check({14'h0, gnt});
    push("tie_gnt1b", 16'h2);
    goto_edge(36); pop_check({14'h0, gnt});

    // 6. Short asynchronous reset pulse while gnt=10 and hold_cnt=1, after
    // the tick on edge 40.
    goto_edge(41);
    #2 reset = 1'b1;
    push("arst_gnt", 16'h0); push("arst_an", 16'hF); push("arst_dsel", 16'h0);
    push("arst_blank", 16'h1);
    #1;
    pop_check({14'h0, gnt}); pop_check({12'h0, an});
    pop_check({14'h0, digit_sel}); pop_check({15'h0, blank});
    #2 reset = 1'b0;
    push("arst_regrant", 16'h1);
    goto_edge(1); pop_check({14'h0, gnt});

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_left observed %0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
